axi_write_slave_sim: RTL and testbench



---
 rtl/axi_write_slave_sim.sv | 188 ++++++++++++++++++
 tb/tb_axi_write_slave_sim.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_slave_sim.sv
// AXI4 write-channel responder for CGRA bring-up benches.
// Turns each accepted W beat into a one-cycle sink write, then returns B.
module axi_write_slave_sim #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                            CLK_I,
  input  logic                            RSTN_I,
  input  logic                            STALL_AW_I,
  input  logic                            STALL_W_I,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWLOCK,
  input  logic [3:0]                      S_AXI_AWCACHE,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic [3:0]                      S_AXI_AWQOS,
  input  logic [3:0]                      S_AXI_AWREGION,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  output logic                            WR_EN_O,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   WR_ADDR_O,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   WR_DATA_O,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] WR_STRB_O,
  output logic                            BURST_DONE_O,
  output logic [15:0]                     BURST_COUNT_O
);

  localparam int IW = C_S_AXI_ID_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;

  localparam logic [2:0] SIZE_EXP = 3'($clog2(SW));
  localparam logic [AW-1:0] BEAT_BYTES = AW'(SW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] id_q, id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    beat_q, beat_d;
  logic          err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [SW-1:0] wr_strb_q, wr_strb_d;
  logic          done_q, done_d;
  logic [15:0]   count_q, count_d;

  logic is_idle, is_data, is_resp;
  logic aw_hs, w_hs, b_hs;
  logic last_beat, wlast_bad;

  // Attribute channels that a bring-up sink has no use for.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                       S_AXI_AWQOS, S_AXI_AWREGION};

  assign is_idle = (state_q == S_IDLE);
  assign is_data = (state_q == S_DATA);
  assign is_resp = (state_q == S_RESP);

  // Ready gated by reset too, so AWREADY is low for the whole reset.
  assign S_AXI_AWREADY = RSTN_I & is_idle & ~STALL_AW_I;
  assign S_AXI_WREADY  = is_data & ~STALL_W_I;
  assign S_AXI_BVALID  = is_resp;
  assign S_AXI_BID     = id_q;
  assign S_AXI_BRESP   = (is_resp && err_q) ? 2'b10 : 2'b00;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;

  assign last_beat = (beat_q == len_q);
  assign wlast_bad = (S_AXI_WLAST != last_beat);

  assign WR_EN_O       = wr_en_q;
  assign WR_ADDR_O     = wr_addr_q;
  assign WR_DATA_O     = wr_data_q;
  assign WR_STRB_O     = wr_strb_q;
  assign BURST_DONE_O  = done_q;
  assign BURST_COUNT_O = count_q;

  // Next-state: burst capture, per-beat sink write and B completion.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    done_d    = 1'b0;
    count_d   = count_q;
    unique case (1'b1)
      is_idle: begin
        if (aw_hs) begin
          id_d    = S_AXI_AWID;
          addr_d  = S_AXI_AWADDR;
          len_d   = S_AXI_AWLEN;
          beat_d  = 8'd0;
          err_d   = (S_AXI_AWBURST != 2'b01) ||
                    (S_AXI_AWSIZE != SIZE_EXP);
          state_d = S_DATA;
        end
      end
      is_data: begin
        if (w_hs) begin
          // A WLAST mismatch poisons this beat and the rest of the burst.
          if (!err_q && !wlast_bad) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = S_AXI_WDATA;
            wr_strb_d = S_AXI_WSTRB;
          end
          if (wlast_bad) begin
            err_d = 1'b1;
          end
          addr_d = addr_q + BEAT_BYTES;
          if (last_beat) begin
            state_d = S_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      is_resp: begin
        if (b_hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any partial burst.
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_axi_write_slave_sim.sv
// Bench for axi_write_slave_sim: directed scenarios plus random bursts
// checked against a per-burst reference of expected sink writes.
module tb_axi_write_slave_sim;

  logic        CLK_I = 1'b0;
  logic        RSTN_I = 1'b0;
  logic        STALL_AW_I = 1'b0;
  logic        STALL_W_I = 1'b0;
  logic [0:0]  S_AXI_AWID = '0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [7:0]  S_AXI_AWLEN = '0;
  logic [2:0]  S_AXI_AWSIZE = 3'd2;
  logic [1:0]  S_AXI_AWBURST = 2'b01;
  logic        S_AXI_AWLOCK = 1'b0;
  logic [3:0]  S_AXI_AWCACHE = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic [3:0]  S_AXI_AWQOS = '0;
  logic [3:0]  S_AXI_AWREGION = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [0:0]  S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic        WR_EN_O;
  logic [31:0] WR_ADDR_O;
  logic [31:0] WR_DATA_O;
  logic [3:0]  WR_STRB_O;
  logic        BURST_DONE_O;
  logic [15:0] BURST_COUNT_O;

  int n_cmp = 0;
  int n_err = 0;
  int exp_count = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t cap_q[$];

  axi_write_slave_sim dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I),
    .STALL_AW_I(STALL_AW_I), .STALL_W_I(STALL_W_I),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
    .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWQOS(S_AXI_AWQOS), .S_AXI_AWREGION(S_AXI_AWREGION),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .WR_EN_O(WR_EN_O), .WR_ADDR_O(WR_ADDR_O),
    .WR_DATA_O(WR_DATA_O), .WR_STRB_O(WR_STRB_O),
    .BURST_DONE_O(BURST_DONE_O), .BURST_COUNT_O(BURST_COUNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  always @(negedge CLK_I)
    if (RSTN_I && WR_EN_O)
      cap_q.push_back({WR_ADDR_O, WR_DATA_O, WR_STRB_O});

  initial begin
    #500us;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit coin(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic aw_send(input logic id, input logic [31:0] addr,
                         input int len, input logic [1:0] bst,
                         input logic [2:0] sz, input int sp);
    int t = 0;
    S_AXI_AWID    = id;
    S_AXI_AWADDR  = addr;
    S_AXI_AWLEN   = 8'(len);
    S_AXI_AWBURST = bst;
    S_AXI_AWSIZE  = sz;
    S_AXI_AWVALID = 1'b1;
    STALL_AW_I    = coin(sp);
    #1;
    while (!S_AXI_AWREADY && t < 200) begin
      @(negedge CLK_I);
      STALL_AW_I = coin(sp);
      #1;
      t++;
    end
    if (!S_AXI_AWREADY) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout: awready=%0b want 1", S_AXI_AWREADY);
    end
    @(posedge CLK_I);
    @(negedge CLK_I);
    S_AXI_AWVALID = 1'b0;
    STALL_AW_I    = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s,
                        input bit last, input int sp);
    int t = 0;
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    S_AXI_WLAST  = last;
    S_AXI_WVALID = 1'b1;
    STALL_W_I    = coin(sp);
    #1;
    while (!S_AXI_WREADY && t < 200) begin
      @(negedge CLK_I);
      STALL_W_I = coin(sp);
      #1;
      t++;
    end
    if (!S_AXI_WREADY) begin
      n_cmp++; n_err++;
      $display("FAIL w_timeout: wready=%0b want 1", S_AXI_WREADY);
    end
    @(posedge CLK_I);
    @(negedge CLK_I);
    S_AXI_WVALID = 1'b0;
    STALL_W_I    = 1'b0;
  endtask

  // Full burst: build expectations from the protocol rules, drive, check.
  task automatic run_burst(input string nm, input logic id,
                           input logic [31:0] addr, input int len,
                           input logic [1:0] bst, input logic [2:0] sz,
                           input int bad, input bit wfirst,
                           input bit seq, input logic [31:0] d0,
                           input int sp);
    logic [31:0] dat[256];
    logic [3:0]  stb[256];
    bit          wl[256];
    wr_t         exp_q[$];
    bit          err;
    int          t;
    err = (bst != 2'b01) || (sz != 3'd2);
    for (int i = 0; i <= len; i++) begin
      dat[i] = seq ? d0 + 32'(i) : $urandom;
      stb[i] = seq ? 4'hF : 4'($urandom);
      wl[i]  = (i == len) ^ (i == bad);
      if (wl[i] != (i == len)) err = 1'b1;
      if (!err) exp_q.push_back({addr + 32'(i * 4), dat[i], stb[i]});
    end
    @(negedge CLK_I);
    cap_q.delete();
    if (wfirst) begin
      S_AXI_WDATA  = dat[0];
      S_AXI_WSTRB  = stb[0];
      S_AXI_WLAST  = wl[0];
      S_AXI_WVALID = 1'b1;
      repeat (2) begin
        @(negedge CLK_I);
        #1;
        n_cmp++;
        if (S_AXI_WREADY !== 1'b0) begin
          n_err++;
          $display("FAIL %s wready_before_aw: got %b want 0",
                   nm, S_AXI_WREADY);
        end
      end
    end
    aw_send(id, addr, len, bst, sz, wfirst ? 0 : sp);
    if (wfirst) begin
      #1;
      n_cmp++;
      if (S_AXI_WREADY !== 1'b1) begin
        n_err++;
        $display("FAIL %s wready_after_aw: got %b want 1",
                 nm, S_AXI_WREADY);
      end
    end
    for (int i = 0; i <= len; i++)
      w_send(dat[i], stb[i], wl[i], wfirst ? 0 : sp);
    #1;
    n_cmp++;
    if (S_AXI_BVALID !== 1'b1) begin
      n_err++;
      $display("FAIL %s bvalid_latency: got %b want 1", nm, S_AXI_BVALID);
    end
    n_cmp++;
    if (S_AXI_BID !== id || S_AXI_BRESP !== (err ? 2'b10 : 2'b00)) begin
      n_err++;
      $display("FAIL %s bresp: got id=%0h resp=%b want id=%0h resp=%b",
               nm, S_AXI_BID, S_AXI_BRESP, id, err ? 2'b10 : 2'b00);
    end
    S_AXI_BREADY = coin(50);
    t = 0;
    while (!(S_AXI_BVALID && S_AXI_BREADY) && t < 200) begin
      @(negedge CLK_I);
      S_AXI_BREADY = coin(50);
      #1;
      t++;
    end
    @(posedge CLK_I);
    @(negedge CLK_I);
    S_AXI_BREADY = 1'b0;
    #1;
    exp_count = (exp_count + 1) % 65536;
    n_cmp++;
    if (BURST_DONE_O !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
      n_err++;
      $display("FAIL %s done: got done=%b bvalid=%b want 1/0",
               nm, BURST_DONE_O, S_AXI_BVALID);
    end
    n_cmp++;
    if (BURST_COUNT_O !== 16'(exp_count)) begin
      n_err++;
      $display("FAIL %s count: got %0d want %0d",
               nm, BURST_COUNT_O, exp_count);
    end
    n_cmp++;
    if (cap_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s nwrites: got %0d want %0d",
               nm, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_cmp++;
      if (cap_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s write%0d: got a=%h d=%h s=%h want a=%h d=%h s=%h",
                 nm, i, cap_q[i].a, cap_q[i].d, cap_q[i].s,
                 exp_q[i].a, exp_q[i].d, exp_q[i].s);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
         S_AXI_BID, WR_EN_O, WR_ADDR_O, WR_DATA_O, WR_STRB_O,
         BURST_DONE_O, BURST_COUNT_O} !== '0) begin
      n_err++;
      $display("FAIL reset_vals: awr=%b wr=%b bv=%b en=%b cnt=%0d want 0",
               S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
               WR_EN_O, BURST_COUNT_O);
    end
    repeat (2) @(negedge CLK_I);
    RSTN_I = 1'b1;
    #1;
    n_cmp++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: awready=%b wready=%b want 1/0",
               S_AXI_AWREADY, S_AXI_WREADY);
    end
  endtask

  task automatic test_min_latency();
    @(negedge CLK_I);
    S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'h40; S_AXI_AWLEN = 8'd0;
    S_AXI_AWBURST = 2'b01; S_AXI_AWSIZE = 3'd2; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1;
    S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    #1;
    n_cmp++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b0) begin
      n_err++;
      $display("FAIL lat_c0: awr=%b wr=%b want 1/0",
               S_AXI_AWREADY, S_AXI_WREADY);
    end
    @(negedge CLK_I);
    S_AXI_AWVALID = 1'b0;
    #1;
    n_cmp++;
    if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b1) begin
      n_err++;
      $display("FAIL lat_c1: awr=%b wr=%b want 0/1",
               S_AXI_AWREADY, S_AXI_WREADY);
    end
    @(negedge CLK_I);
    S_AXI_WVALID = 1'b0;
    #1;
    n_cmp++;
    if (S_AXI_BVALID !== 1'b1 || WR_EN_O !== 1'b1 ||
        WR_ADDR_O !== 32'h40 || WR_DATA_O !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL lat_c2: bv=%b en=%b a=%h d=%h want 1/1/40/12345678",
               S_AXI_BVALID, WR_EN_O, WR_ADDR_O, WR_DATA_O);
    end
    @(negedge CLK_I);
    S_AXI_BREADY = 1'b0;
    #1;
    exp_count++;
    n_cmp++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 ||
        BURST_DONE_O !== 1'b1 || WR_EN_O !== 1'b0 ||
        BURST_COUNT_O !== 16'(exp_count)) begin
      n_err++;
      $display("FAIL lat_c3: bv=%b awr=%b done=%b en=%b cnt=%0d want 0/1/1/0/%0d",
               S_AXI_BVALID, S_AXI_AWREADY, BURST_DONE_O, WR_EN_O,
               BURST_COUNT_O, exp_count);
    end
  endtask

  task automatic test_directed();
    run_burst("single", 1'b1, 32'h100, 0, 2'b01, 3'd2, -1, 1'b0,
              1'b1, 32'hDEAD_BEEF, 0);
    run_burst("incr_stall", 1'b0, 32'h200, 3, 2'b01, 3'd2, -1, 1'b0,
              1'b1, 32'h0, 50);
    run_burst("data_first", 1'b1, 32'h280, 1, 2'b01, 3'd2, -1, 1'b1,
              1'b1, 32'hA5A5_0000, 0);
    run_burst("wrap_burst", 1'b0, 32'h400, 1, 2'b10, 3'd2, -1, 1'b0,
              1'b1, 32'h5, 0);
    run_burst("early_wlast", 1'b1, 32'h500, 2, 2'b01, 3'd2, 1, 1'b0,
              1'b1, 32'h77, 0);
    run_burst("addr_wrap", 1'b0, 32'hFFFF_FFF8, 3, 2'b01, 3'd2, -1,
              1'b0, 1'b1, 32'h9, 20);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int len;
      int bad;
      logic [1:0] bst;
      logic [2:0] sz;
      len = $urandom_range(0, 7);
      bad = coin(25) ? int'($urandom_range(0, len)) : -1;
      bst = coin(12) ? 2'b10 : 2'b01;
      sz  = coin(12) ? 3'd1 : 3'd2;
      run_burst("random", 1'($urandom), $urandom, len, bst, sz, bad,
                coin(15), 1'b0, 32'h0, $urandom_range(0, 60));
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge CLK_I);
    aw_send(1'b1, 32'h300, 7, 2'b01, 3'd2, 0);
    w_send(32'h1111_1111, 4'hF, 1'b0, 0);
    w_send(32'h2222_2222, 4'hF, 1'b0, 0);
    S_AXI_WVALID = 1'b1;
    RSTN_I = 1'b0;
    #1;
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
         S_AXI_BID, WR_EN_O, WR_ADDR_O, WR_DATA_O, WR_STRB_O,
         BURST_DONE_O, BURST_COUNT_O} !== '0) begin
      n_err++;
      $display("FAIL midrst_zero: awr=%b wr=%b bv=%b en=%b a=%h d=%h cnt=%0d want 0",
               S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, WR_EN_O,
               WR_ADDR_O, WR_DATA_O, BURST_COUNT_O);
    end
    S_AXI_WVALID = 1'b0;
    exp_count = 0;
    repeat (2) @(negedge CLK_I);
    RSTN_I = 1'b1;
    #1;
    n_cmp++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0 ||
        BURST_COUNT_O !== 16'd0) begin
      n_err++;
      $display("FAIL midrst_release: awr=%b bv=%b cnt=%0d want 1/0/0",
               S_AXI_AWREADY, S_AXI_BVALID, BURST_COUNT_O);
    end
    run_burst("after_rst", 1'b0, 32'h600, 2, 2'b01, 3'd2, -1, 1'b0,
              1'b0, 32'h0, 30);
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_directed();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
